// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order writeback buffer for the register file.
// Buffers ALU and load writes in a small FIFO, drains one entry per cycle
// onto the registered write port, and reports which source registers still
// have a write outstanding so decode can stall.
//
// Handshake: a request transfers on a rising edge where valid && ready are
// both high. Ready depends only on current occupancy and flush, never on
// whether the head is being popped in the same cycle. The load path wins
// over the ALU path when both are valid.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [AW-1:0]              alu_addr,
    input  logic [DW-1:0]              alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [AW-1:0]              mem_addr,
    input  logic [DW-1:0]              mem_data,
    output logic                       we,
    output logic [AW-1:0]              waddr,
    output logic [DW-1:0]              wdata,
    input  logic [AW-1:0]              rs_addr,
    input  logic [AW-1:0]              rt_addr,
    output logic                       rs_busy,
    output logic                       rt_busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];

    logic          full;
    logic          push;
    logic          pop;
    logic [AW-1:0] push_addr;
    logic [DW-1:0] push_data;

    // Acceptance: load path has priority; zero-register writes handshake but are dropped.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        mem_ready = !full && !flush;
        alu_ready = !full && !flush && !mem_valid;
        push_addr = mem_valid ? mem_addr : alu_addr;
        push_data = mem_valid ? mem_data : alu_data;
        push      = ((mem_valid && mem_ready) || (alu_valid && alu_ready)) &&
                    (push_addr != '0);
        pop       = (count_q != '0) && !flush;
    end

    // Next-state for pointers, occupancy and the registered write port.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (pop) begin
                we_d     = 1'b1;
                waddr_d  = addr_mem_q[rd_ptr_q];
                wdata_d  = data_mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control and write-port registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // FIFO storage; contents are only read while the slot is occupied, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= push_addr;
            data_mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Scoreboard: a source is busy if any occupied slot or the write port targets it.
    always_comb begin
        logic [PW-1:0] off;
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (CW'(off) < count_q) begin
                if (addr_mem_q[i] == rs_addr) rs_busy = 1'b1;
                if (addr_mem_q[i] == rt_addr) rt_busy = 1'b1;
            end
        end
        if (we_q && waddr_q == rs_addr) rs_busy = 1'b1;
        if (we_q && waddr_q == rt_addr) rt_busy = 1'b1;
        if (rs_addr == '0) rs_busy = 1'b0;
        if (rt_addr == '0) rt_busy = 1'b0;
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign count = count_q;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed steps plus random traffic, checked against a
// queue-based model of the writeback buffer.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_addr, mem_addr, rs_addr, rt_addr;
  logic [DW-1:0] alu_data, mem_data;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          rs_busy, rt_busy;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] regs [32];

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .we(we), .waddr(waddr), .wdata(wdata),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .count(count)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_busy(input logic [AW-1:0] r);
    if (r == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].a == r) return 1'b1;
    return m_we && (m_waddr == r);
  endfunction

  task automatic idle_inputs();
    flush = 0; alu_valid = 0; mem_valid = 0;
    alu_addr = 0; alu_data = 0; mem_addr = 0; mem_data = 0;
  endtask

  // One clock: check combinational outputs, take the edge, update model, check registers.
  task automatic cycle();
    ent_t e;
    logic acc;
    #1;
    check("mem_ready", mem_ready, (mq.size() < DEPTH) && !flush);
    check("alu_ready", alu_ready, (mq.size() < DEPTH) && !flush && !mem_valid);
    check("rs_busy", rs_busy, model_busy(rs_addr));
    check("rt_busy", rt_busy, model_busy(rt_addr));
    @(posedge clk);
    acc = 0;
    if (!flush && mq.size() < DEPTH) begin
      if (mem_valid) begin e.a = mem_addr; e.d = mem_data; acc = 1; end
      else if (alu_valid) begin e.a = alu_addr; e.d = alu_data; acc = 1; end
    end
    if (flush) begin
      mq.delete();
      m_we = 0;
    end else begin
      if (mq.size() > 0) begin
        m_we = 1; m_waddr = mq[0].a; m_wdata = mq[0].d;
        regs[m_waddr] = m_wdata;
        void'(mq.pop_front());
      end else begin
        m_we = 0;
      end
      if (acc && e.a != 0) mq.push_back(e);
    end
    #1;
    check("we", we, m_we);
    check("waddr", waddr, m_waddr);
    check("wdata", wdata, m_wdata);
    check("count", count, mq.size());
    @(negedge clk);
  endtask

  initial begin
    // Reset
    rst = 0; rs_addr = 0; rt_addr = 0;
    idle_inputs();
    mq.delete(); m_we = 0; m_waddr = 0; m_wdata = 0;
    foreach (regs[i]) regs[i] = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_we", we, 1'b0);
    check("rst_count", count, 0);
    check("rst_waddr", waddr, 0);
    rst = 1;
    @(negedge clk);
    cycle();
    check("idle_alu_ready", alu_ready, 1'b1);

    // Single ALU write with busy tracking
    rs_addr = 5; rt_addr = 6;
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    cycle();
    check("single_we", we, 1'b1);
    check("single_waddr", waddr, 5);
    check("single_wdata", wdata, 32'hDEADBEEF);
    cycle();
    cycle();
    check("single_busy_clear", rs_busy, 1'b0);

    // Priority: mem and alu to the same register
    rs_addr = 3;
    mem_valid = 1; mem_addr = 3; mem_data = 32'h11;
    alu_valid = 1; alu_addr = 3; alu_data = 32'h22;
    cycle();
    mem_valid = 0;
    cycle();
    idle_inputs();
    repeat (3) cycle();
    check("prio_final", regs[3], 32'h22);

    // Zero register
    rs_addr = 0;
    alu_valid = 1; alu_addr = 0; alu_data = 32'h1234;
    cycle();
    idle_inputs();
    repeat (2) cycle();

    // Flush with an entry queued
    rs_addr = 9;
    mem_valid = 1; mem_addr = 9; mem_data = 32'hA5A5;
    cycle();
    idle_inputs();
    flush = 1;
    cycle();
    flush = 0;
    cycle();
    check("flush_count", count, 0);

    // Asynchronous reset mid-drain
    alu_valid = 1; alu_addr = 7; alu_data = 32'h77;
    cycle();
    alu_valid = 1; alu_addr = 8; alu_data = 32'h88;
    cycle();
    idle_inputs();
    rst = 0;
    #1;
    check("arst_we", we, 1'b0);
    check("arst_count", count, 0);
    check("arst_wdata", wdata, 0);
    mq.delete(); m_we = 0; m_waddr = 0; m_wdata = 0;
    @(negedge clk);
    rst = 1;
    cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      mem_valid = ($urandom_range(0, 2) == 0);
      alu_valid = ($urandom_range(0, 1) == 1);
      mem_addr  = AW'($urandom_range(0, 7));
      alu_addr  = AW'($urandom_range(0, 7));
      mem_data  = $urandom;
      alu_data  = $urandom;
      rs_addr   = AW'($urandom_range(0, 7));
      rt_addr   = AW'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
